// File: rtl/tlb_assoc.sv
// Fully associative translation cache with a two-level page-table walker.
// A hit answers from the cache; a miss walks directory then table and fills an entry.
//
// state   | meaning
// IDLE    | waiting for a lookup; compares the request against cached entries
// DIR     | reading the page-directory entry
// PTE     | reading the leaf page-table entry
// ACK     | one-cycle answer pulse with the translated PTE
// FAULT   | one-cycle answer pulse reporting a page fault
// WAIT    | holding until the requester drops v_lookup
module tlb_assoc #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmu_base_i,
  input  logic        mmu_we,
  output logic [31:0] mmu_base_o,
  input  logic        flush_i,
  input  logic [31:0] v_addr_i,
  input  logic        v_lookup,
  output logic [31:0] v_ent_o,
  output logic [19:0] v_page_o,
  output logic        v_ack_o,
  output logic        hit_o,
  output logic [31:0] addr_o,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        we_o,
  output logic        rd_o,
  input  logic        ack_i,
  output logic        page_fault,
  output logic [31:0] page_fault_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIR, S_PTE, S_ACK, S_FAULT, S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q;
  logic [31:0]        vaddr_q;
  logic [31:0]        addr_q;
  logic [31:0]        ent_q;
  logic [19:0]        page_q;
  logic               hit_q;
  logic [31:0]        fault_addr_q;
  logic               no_fill_q;
  logic [ENTRIES-1:0] valid_q;
  logic [19:0]        vpn_q [ENTRIES];
  logic [31:0]        pte_q [ENTRIES];
  logic [IDX_W-1:0]   rpl_q;

  logic               hit_any;
  logic [31:0]        hit_pte;
  logic               free_any;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               flush_evt;
  logic               fill_en;

  assign flush_evt = flush_i | mmu_we;

  always_comb begin
    hit_any = 1'b0;
    hit_pte = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == v_addr_i[31:12]) begin
        hit_any = 1'b1;
        hit_pte = pte_q[i];
      end
    end
  end

  // Scan downwards so the lowest invalid index wins.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign victim  = free_any ? free_idx : rpl_q;
  assign fill_en = (state_q == S_PTE) && ack_i && data_i[0] && !no_fill_q && !flush_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (v_lookup) state_d = hit_any ? S_ACK : S_DIR;
      S_DIR:   if (ack_i) state_d = data_i[0] ? S_PTE : S_FAULT;
      S_PTE:   if (ack_i) state_d = data_i[0] ? S_ACK : S_FAULT;
      S_ACK:   state_d = S_WAIT;
      S_FAULT: state_d = S_WAIT;
      S_WAIT:  if (!v_lookup) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      vaddr_q      <= '0;
      addr_q       <= '0;
      ent_q        <= '0;
      page_q       <= '0;
      hit_q        <= 1'b0;
      fault_addr_q <= '0;
      no_fill_q    <= 1'b0;
    end else begin
      if (mmu_we) base_q <= mmu_base_i;
      case (state_q)
        S_IDLE: begin
          if (v_lookup) begin
            vaddr_q   <= v_addr_i;
            no_fill_q <= 1'b0;
            hit_q     <= hit_any;
            if (hit_any) begin
              ent_q  <= hit_pte;
              page_q <= v_addr_i[31:12];
            end else begin
              addr_q <= base_q + {20'b0, v_addr_i[31:22], 2'b00};
            end
          end
        end
        S_DIR: begin
          if (flush_evt) no_fill_q <= 1'b1;
          if (ack_i) begin
            if (data_i[0]) begin
              addr_q <= {data_i[31:12], 12'h000} + {20'b0, vaddr_q[21:12], 2'b00};
            end else begin
              ent_q        <= '0;
              page_q       <= vaddr_q[31:12];
              fault_addr_q <= vaddr_q;
            end
          end
        end
        S_PTE: begin
          if (flush_evt) no_fill_q <= 1'b1;
          if (ack_i) begin
            page_q <= vaddr_q[31:12];
            if (data_i[0]) begin
              ent_q <= data_i;
            end else begin
              ent_q        <= '0;
              fault_addr_q <= vaddr_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A flush in the fill cycle suppresses the fill via fill_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rpl_q   <= '0;
    end else begin
      if (flush_evt)    valid_q         <= '0;
      else if (fill_en) valid_q[victim] <= 1'b1;
      if (fill_en && !free_any) rpl_q <= rpl_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_q[victim] <= vaddr_q[31:12];
      pte_q[victim] <= data_i;
    end
  end

  assign mmu_base_o      = base_q;
  assign v_ent_o         = ent_q;
  assign v_page_o        = page_q;
  assign v_ack_o         = (state_q == S_ACK) || (state_q == S_FAULT);
  assign hit_o           = (state_q == S_ACK) && hit_q;
  assign page_fault      = (state_q == S_FAULT);
  assign page_fault_addr = fault_addr_q;
  assign rd_o            = (state_q == S_DIR) || (state_q == S_PTE);
  assign addr_o          = addr_q;
  assign data_o          = '0;
  assign we_o            = 1'b0;

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed bench for tlb_assoc: walk, hit, fault, base write, eviction and
// flush-during-walk scenarios against a small associative memory model.
module tb_tlb_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mmu_base_i = '0;
  logic        mmu_we = 1'b0;
  logic [31:0] mmu_base_o;
  logic        flush_i = 1'b0;
  logic [31:0] v_addr_i = '0;
  logic        v_lookup = 1'b0;
  logic [31:0] v_ent_o;
  logic [19:0] v_page_o;
  logic        v_ack_o;
  logic        hit_o;
  logic [31:0] addr_o;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        we_o;
  logic        rd_o;
  logic        ack_i = 1'b0;
  logic        page_fault;
  logic [31:0] page_fault_addr;

  tlb_assoc #(.ENTRIES(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .mmu_base_i(mmu_base_i), .mmu_we(mmu_we), .mmu_base_o(mmu_base_o),
    .flush_i(flush_i),
    .v_addr_i(v_addr_i), .v_lookup(v_lookup),
    .v_ent_o(v_ent_o), .v_page_o(v_page_o), .v_ack_o(v_ack_o), .hit_o(hit_o),
    .addr_o(addr_o), .data_i(data_i), .data_o(data_o), .we_o(we_o),
    .rd_o(rd_o), .ack_i(ack_i),
    .page_fault(page_fault), .page_fault_addr(page_fault_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];

  // Memory answers every read one cycle after the strobe appears.
  always @(negedge clk) begin
    if (rd_o && !ack_i) begin
      ack_i  = 1'b1;
      data_i = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
      rd_log.push_back(addr_o);
    end else begin
      ack_i = 1'b0;
    end
  end

  logic        flush_arm = 1'b0;
  logic [31:0] flush_addr = '0;

  always @(negedge clk) begin
    if (flush_arm && rd_o && addr_o == flush_addr) begin
      flush_i   = 1'b1;
      flush_arm = 1'b0;
    end else begin
      flush_i = 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] r_ent, r_pfa;
  logic [19:0] r_page;
  logic        r_hit, r_pf;
  int          r_cyc;

  task automatic lookup(input logic [31:0] va);
    bit done;
    done = 1'b0;
    rd_log.delete();
    @(negedge clk);
    v_addr_i = va;
    v_lookup = 1'b1;
    r_cyc = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      r_cyc++;
      if (v_ack_o) begin
        done   = 1'b1;
        r_ent  = v_ent_o;
        r_page = v_page_o;
        r_hit  = hit_o;
        r_pf   = page_fault;
        r_pfa  = page_fault_addr;
      end
    end
    check("ack_timeout", 32'(done), 32'd1);
    v_lookup = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_base(input logic [31:0] b);
    @(negedge clk);
    mmu_base_i = b;
    mmu_we     = 1'b1;
    @(negedge clk);
    mmu_we     = 1'b0;
  endtask

  initial begin
    mem[32'h0000_0000] = 32'h0001_0001;
    mem[32'h0001_0000] = 32'h0000_0001;
    mem[32'h0001_0008] = 32'h0000_0000;
    mem[32'h0000_0004] = 32'h0002_0001;
    mem[32'h0002_0000] = 32'h000F_0001;
    mem[32'h0003_0000] = 32'h0002_0001;
    mem[32'h0001_00C0] = 32'h00AB_C001;
    for (int i = 0; i < 9; i++)
      mem[32'h0001_0040 + 32'(4 * i)] = ((32'h100 + 32'(i)) << 12) | 32'h1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(v_ack_o), 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    check("rst_base", mmu_base_o, 32'h0);
    check("rst_ent", v_ent_o, 32'h0);
    check("rst_pf", 32'(page_fault), 32'd0);
    check("rst_addr", addr_o, 32'h0);

    // Cold miss
    lookup(32'h0000_0000);
    check("cold_nreads", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("cold_dir_addr", rd_log[0], 32'h0000_0000);
      check("cold_pte_addr", rd_log[1], 32'h0001_0000);
    end
    check("cold_ent", r_ent, 32'h0000_0001);
    check("cold_page", 32'(r_page), 32'h0);
    check("cold_hit", 32'(r_hit), 32'd0);
    check("cold_lat", 32'(r_cyc), 32'd4);

    // Hit in the same page
    lookup(32'h0000_0ABC);
    check("hit_nreads", 32'(rd_log.size()), 32'd0);
    check("hit_lat", 32'(r_cyc), 32'd1);
    check("hit_hit", 32'(r_hit), 32'd1);
    check("hit_ent", r_ent, 32'h0000_0001);

    // Fault, then repeated fault must walk again
    lookup(32'h0000_2000);
    check("flt_pf", 32'(r_pf), 32'd1);
    check("flt_addr", r_pfa, 32'h0000_2000);
    check("flt_ent", r_ent, 32'h0);
    check("flt_hit", 32'(r_hit), 32'd0);
    lookup(32'h0000_2000);
    check("flt2_nreads", 32'(rd_log.size()), 32'd2);
    check("flt2_pf", 32'(r_pf), 32'd1);

    // Second directory slot
    lookup(32'h0040_0000);
    check("dir1_nreads", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("dir1_dir_addr", rd_log[0], 32'h0000_0004);
      check("dir1_pte_addr", rd_log[1], 32'h0002_0000);
    end
    check("dir1_ent", r_ent, 32'h000F_0001);
    check("dir1_page", 32'(r_page), 32'h400);
    check("dir1_pf", 32'(r_pf), 32'd0);

    // Base write flushes and redirects the walk
    write_base(32'h0003_0000);
    check("base_o", mmu_base_o, 32'h0003_0000);
    lookup(32'h0000_0000);
    check("base_hit", 32'(r_hit), 32'd0);
    check("base_nreads", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("base_dir_addr", rd_log[0], 32'h0003_0000);
      check("base_pte_addr", rd_log[1], 32'h0002_0000);
    end
    check("base_ent", r_ent, 32'h000F_0001);

    // Eviction: nine distinct pages into eight slots
    write_base(32'h0000_0000);
    for (int i = 0; i < 9; i++) begin
      lookup((32'd16 + 32'(i)) << 12);
      check("ev_fill_hit", 32'(r_hit), 32'd0);
      check("ev_fill_ent", r_ent, ((32'h100 + 32'(i)) << 12) | 32'h1);
    end
    lookup(32'd17 << 12);
    check("ev_second_hit", 32'(r_hit), 32'd1);
    check("ev_second_ent", r_ent, 32'h0010_1001);
    lookup(32'd16 << 12);
    check("ev_first_hit", 32'(r_hit), 32'd0);
    check("ev_first_nreads", 32'(rd_log.size()), 32'd2);
    check("ev_first_ent", r_ent, 32'h0010_0001);

    // Flush during the leaf read: answer still given, no fill
    flush_addr = 32'h0001_00C0;
    flush_arm  = 1'b1;
    lookup(32'h0003_0000);
    check("fl_armed_used", 32'(flush_arm), 32'd0);
    check("fl_ent", r_ent, 32'h00AB_C001);
    check("fl_hit", 32'(r_hit), 32'd0);
    lookup(32'h0003_0000);
    check("fl_again_hit", 32'(r_hit), 32'd0);
    check("fl_again_nreads", 32'(rd_log.size()), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
